// File: rtl/cpu_ext_pkg.sv
// Shared definitions for the cpu external-memory loader.
// Holds the controller state encoding and the default widths and address step.
package cpu_ext_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned CNT_W_DEF     = 10;
  localparam int unsigned ADDR_STEP_DEF = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_HOLD  = 3'd4,
    RUN      = 3'd5
  } state_t;

endpackage

// File: rtl/reg_arstn_en.sv
// Generic register with load enable and asynchronous active-low clear.
// Ports: clk, arst_n (async clear to 0), en (load), d (next value), q (registered value).
module reg_arstn_en #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cpu_ext_loader.sv
// Host-side master for the cpu external memory port.
// Loads a valid/ready stream into memory, dumps a memory window out over valid/ready,
// and gates the cpu enable so the cpu only runs while no transfer is in progress.
// Ports:
//   clk, arst_n                         clock and asynchronous active-low reset
//   start_load/start_dump/start_run     one-cycle commands, accepted only when idle
//   stop_run                            leave the run state
//   base, len                           transfer start byte address and word count
//   in_valid/in_data/in_ready           load stream (in_ready combinational)
//   out_valid/out_data/out_ready        dump stream
//   addr_ext/wen_ext/ren_ext/wdata_ext  memory port requests
//   rdata_ext                           memory read data, valid one cycle after ren_ext
//   cpu_enable                          cpu run enable
//   busy (combinational), done          transfer status; done pulses at end of load/dump
module cpu_ext_loader
  import cpu_ext_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic              start_run,
  input  logic              stop_run,
  input  logic [31:0]       base,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [31:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done
);

  localparam logic [31:0] STEP = 32'(ADDR_STEP);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [31:0]        ptr_q, ptr_d;
  logic [31:0]        addr_d;
  logic [DATA_W-1:0]  wdata_d;
  logic               wen_d, ren_d, done_d, out_valid_d, cpu_enable_d;
  logic               last;

  // Current word is the final one of the transfer.
  assign last     = (k_q == (len_q - CNT_W'(1)));
  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE) && (state_q != RUN);

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      len_q      <= '0;
      ptr_q      <= '0;
      addr_ext   <= '0;
      wdata_ext  <= '0;
      wen_ext    <= 1'b0;
      ren_ext    <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      cpu_enable <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_q      <= len_d;
      ptr_q      <= ptr_d;
      addr_ext   <= addr_d;
      wdata_ext  <= wdata_d;
      wen_ext    <= wen_d;
      ren_ext    <= ren_d;
      done       <= done_d;
      out_valid  <= out_valid_d;
      cpu_enable <= cpu_enable_d;
    end
  end

  // Next-state and next-output logic. ptr_q always holds the address of the next word.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    addr_d  = addr_ext;
    wdata_d = wdata_ext;
    wen_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_load) begin
          len_d = len;
          k_d   = '0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = LOAD;
            ptr_d   = base;
          end
        end else if (start_dump) begin
          len_d = len;
          k_d   = '0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RD_ISSUE;
            addr_d  = base;
            ptr_d   = base + STEP;
          end
        end else if (start_run) begin
          state_d = RUN;
        end
      end

      LOAD: begin
        if (in_valid) begin
          wen_d   = 1'b1;
          addr_d  = ptr_q;
          wdata_d = in_data;
          ptr_d   = ptr_q + STEP;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            k_d     = '0;
          end else begin
            k_d = k_q + CNT_W'(1);
          end
        end
      end

      RD_ISSUE: state_d = RD_WAIT;

      RD_WAIT: state_d = RD_HOLD;

      RD_HOLD: begin
        if (out_ready) begin
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            k_d     = '0;
          end else begin
            state_d = RD_ISSUE;
            k_d     = k_q + CNT_W'(1);
            addr_d  = ptr_q;
            ptr_d   = ptr_q + STEP;
          end
        end
      end

      RUN: begin
        if (stop_run) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Strobes that simply follow the state being entered.
  assign ren_d        = (state_d == RD_ISSUE);
  assign out_valid_d  = (state_d == RD_HOLD);
  assign cpu_enable_d = (state_d == RUN);

  // Read data arrives during RD_WAIT and is held as the dump word until handshake.
  reg_arstn_en #(
    .W (DATA_W)
  ) u_rd_cap (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (state_q == RD_WAIT),
    .d      (rdata_ext),
    .q      (out_data)
  );

endmodule

// File: tb/tb_cpu_ext_loader.sv
// Directed self-checking bench for cpu_ext_loader with a small word memory model.
module tb_cpu_ext_loader;

  logic        clk;
  logic        arst_n;
  logic        start_load, start_dump, start_run, stop_run;
  logic [31:0] base;
  logic [9:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [31:0] addr_ext;
  logic        wen_ext, ren_ext;
  logic [31:0] wdata_ext;
  logic [31:0] rdata_ext;
  logic        cpu_enable, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [64];

  cpu_ext_loader dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .start_load (start_load),
    .start_dump (start_dump),
    .start_run  (start_run),
    .stop_run   (stop_run),
    .base       (base),
    .len        (len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .ren_ext    (ren_ext),
    .wdata_ext  (wdata_ext),
    .rdata_ext  (rdata_ext),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous word memory: write on wen, registered read data one cycle after ren.
  always @(posedge clk) begin
    if (wen_ext) mem[addr_ext[7:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= mem[addr_ext[7:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered with the DUT in RD_ISSUE for this word; leaves one cycle after the handshake.
  task automatic dump_word(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data, input int hold, input bit is_last);
    chk({tag, ".ren"}, 32'(ren_ext), 32'd1);
    chk({tag, ".addr"}, addr_ext, exp_addr);
    chk({tag, ".wen"}, 32'(wen_ext), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, ".wait_ren"}, 32'(ren_ext), 32'd0);
    chk({tag, ".wait_vld"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, ".vld"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, out_data, exp_data);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold_vld"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_data"}, out_data, exp_data);
      chk({tag, ".hold_ren"}, 32'(ren_ext), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'(is_last));
  endtask

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0003;
    prog[2] = 32'h0109_5020;
    prog[3] = 32'hAC0A_0000;

    arst_n = 1'b0; start_load = 1'b0; start_dump = 1'b0; start_run = 1'b0;
    stop_run = 1'b0; base = '0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst.wen", 32'(wen_ext), 32'd0);
    chk("rst.ren", 32'(ren_ext), 32'd0);
    chk("rst.addr", addr_ext, 32'd0);
    chk("rst.cpu_en", 32'(cpu_enable), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    arst_n = 1'b1;
    tick();

    // 1: back-to-back load of four words at base 0
    start_load = 1'b1; base = 32'h0; len = 10'd4;
    tick();
    start_load = 1'b0;
    chk("t1.in_ready", 32'(in_ready), 32'd1);
    chk("t1.busy", 32'(busy), 32'd1);
    chk("t1.wen_pre", 32'(wen_ext), 32'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = prog[i];
      tick();
      chk("t1.wen", 32'(wen_ext), 32'd1);
      chk("t1.addr", addr_ext, 32'(i * 4));
      chk("t1.wdata", wdata_ext, prog[i]);
      chk("t1.done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    chk("t1.idle_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t1.wen_off", 32'(wen_ext), 32'd0);
    chk("t1.done_off", 32'(done), 32'd0);

    // 1b: readback of the loaded program
    start_dump = 1'b1; base = 32'h0; len = 10'd4;
    tick();
    start_dump = 1'b0;
    for (int i = 0; i < 4; i++) dump_word("t1.rb", 32'(i * 4), prog[i], 0, i == 3);
    tick();
    chk("t1.rb_done_off", 32'(done), 32'd0);

    // 2: load with in_valid gaps
    start_load = 1'b1; base = 32'h10; len = 10'd3;
    tick();
    start_load = 1'b0;
    in_valid = 1'b1; in_data = 32'hAAAA_0001;
    tick();
    chk("t2.w0_wen", 32'(wen_ext), 32'd1);
    chk("t2.w0_addr", addr_ext, 32'h10);
    in_valid = 1'b0; in_data = 32'hBAD0_BAD0;
    tick();
    chk("t2.gap0_wen", 32'(wen_ext), 32'd0);
    chk("t2.gap0_wdata", wdata_ext, 32'hAAAA_0001);
    in_valid = 1'b1; in_data = 32'hBBBB_0002;
    tick();
    chk("t2.w1_wen", 32'(wen_ext), 32'd1);
    chk("t2.w1_addr", addr_ext, 32'h14);
    chk("t2.w1_done", 32'(done), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("t2.gap1_wen", 32'(wen_ext), 32'd0);
    in_valid = 1'b1; in_data = 32'hCCCC_0003;
    tick();
    in_valid = 1'b0;
    chk("t2.w2_wen", 32'(wen_ext), 32'd1);
    chk("t2.w2_addr", addr_ext, 32'h18);
    chk("t2.w2_wdata", wdata_ext, 32'hCCCC_0003);
    chk("t2.done", 32'(done), 32'd1);
    tick();

    // 3: dump of three words with a stalled consumer on word 1
    start_dump = 1'b1; base = 32'h10; len = 10'd3;
    tick();
    start_dump = 1'b0;
    dump_word("t3.w0", 32'h10, 32'hAAAA_0001, 0, 1'b0);
    dump_word("t3.w1", 32'h14, 32'hBBBB_0002, 5, 1'b0);
    dump_word("t3.w2", 32'h18, 32'hCCCC_0003, 0, 1'b1);
    chk("t3.busy", 32'(busy), 32'd0);
    tick();

    // 4: run, commands ignored while running, stop
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    chk("t4.cpu_en", 32'(cpu_enable), 32'd1);
    chk("t4.busy", 32'(busy), 32'd0);
    start_load = 1'b1; base = 32'h0; len = 10'd1;
    tick();
    start_load = 1'b0;
    chk("t4.load_ign_ready", 32'(in_ready), 32'd0);
    chk("t4.load_ign_cpu", 32'(cpu_enable), 32'd1);
    in_valid = 1'b1; in_data = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    chk("t4.load_ign_wen", 32'(wen_ext), 32'd0);
    stop_run = 1'b1;
    tick();
    chk("t4.stop_cpu", 32'(cpu_enable), 32'd0);
    tick();
    stop_run = 1'b0;
    chk("t4.stop_idle_cpu", 32'(cpu_enable), 32'd0);
    chk("t4.stop_idle_busy", 32'(busy), 32'd0);

    // 5: reset in the middle of a load, then a fresh one-word load
    start_load = 1'b1; base = 32'h40; len = 10'd4;
    tick();
    start_load = 1'b0;
    in_valid = 1'b1; in_data = 32'h5555_0000;
    tick();
    in_data = 32'h5555_0001;
    tick();
    chk("t5.pre_wen", 32'(wen_ext), 32'd1);
    chk("t5.pre_addr", addr_ext, 32'h44);
    in_valid = 1'b0;
    arst_n = 1'b0;
    #1;
    chk("t5.rst_wen", 32'(wen_ext), 32'd0);
    chk("t5.rst_addr", addr_ext, 32'd0);
    chk("t5.rst_wdata", wdata_ext, 32'd0);
    chk("t5.rst_in_ready", 32'(in_ready), 32'd0);
    chk("t5.rst_busy", 32'(busy), 32'd0);
    chk("t5.rst_out_data", out_data, 32'd0);
    #2;
    arst_n = 1'b1;
    start_load = 1'b1; base = 32'h0; len = 10'd1;
    tick();
    start_load = 1'b0;
    chk("t5.new_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    chk("t5.new_wen", 32'(wen_ext), 32'd1);
    chk("t5.new_addr", addr_ext, 32'h0);
    chk("t5.new_done", 32'(done), 32'd1);
    tick();
    start_dump = 1'b1; base = 32'h0; len = 10'd1;
    tick();
    start_dump = 1'b0;
    dump_word("t5.rb", 32'h0, 32'hDEAD_BEEF, 0, 1'b1);
    tick();

    // 6: zero-length transfers and command priority
    start_load = 1'b1; base = 32'h8; len = 10'd0;
    tick();
    start_load = 1'b0;
    chk("t6.l0_done", 32'(done), 32'd1);
    chk("t6.l0_wen", 32'(wen_ext), 32'd0);
    chk("t6.l0_busy", 32'(busy), 32'd0);
    tick();
    chk("t6.l0_done_off", 32'(done), 32'd0);
    start_dump = 1'b1; base = 32'h8; len = 10'd0;
    tick();
    start_dump = 1'b0;
    chk("t6.d0_done", 32'(done), 32'd1);
    chk("t6.d0_ren", 32'(ren_ext), 32'd0);
    chk("t6.d0_vld", 32'(out_valid), 32'd0);
    tick();
    chk("t6.d0_done_off", 32'(done), 32'd0);
    start_load = 1'b1; start_dump = 1'b1; base = 32'h20; len = 10'd1;
    tick();
    start_load = 1'b0; start_dump = 1'b0;
    chk("t6.pri_ready", 32'(in_ready), 32'd1);
    chk("t6.pri_ren", 32'(ren_ext), 32'd0);
    in_valid = 1'b1; in_data = 32'h0F0F_0F0F;
    tick();
    in_valid = 1'b0;
    chk("t6.pri_wen", 32'(wen_ext), 32'd1);
    chk("t6.pri_addr", addr_ext, 32'h20);
    chk("t6.pri_done", 32'(done), 32'd1);
    chk("t6.pri_ren2", 32'(ren_ext), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
